// File: rtl/mem_arbiter_2port_32bit.sv
// Round-robin arbiter sharing one 32-bit RAM (four byte lanes) between the CPU data port (A)
// and the debug loader (B). Each access takes an issue cycle followed by a completion cycle.
module mem_arbiter_2port_32bit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [3:0]            a_be,
    input  logic [31:0]           a_wdata,
    output logic                  a_ack,
    output logic [31:0]           a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [3:0]            b_be,
    input  logic [31:0]           b_wdata,
    output logic                  b_ack,
    output logic [31:0]           b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_we,
    input  logic [31:0]           mem_dout
);

    // state   | meaning
    // IDLE    | no access in flight; issues the winner's access this cycle
    // DONE_A  | port A access completing; ack and read data to A
    // DONE_B  | port B access completing; ack and read data to B
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DONE_A = 2'd1,
        DONE_B = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    state_t state_q, state_d;
    grant_t last_grant_q, last_grant_d;
    logic   win_a, win_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_B;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On a tie the port that did not win last time goes next.
    assign win_a = a_req && (!b_req || (last_grant_q == GRANT_B));
    assign win_b = b_req && !win_a;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr     = '0;
        mem_din      = '0;
        mem_we       = '0;
        a_ack        = 1'b0;
        a_rdata      = '0;
        b_ack        = 1'b0;
        b_rdata      = '0;
        unique case (state_q)
            IDLE: begin
                if (win_a) begin
                    mem_addr     = a_addr;
                    mem_din      = a_wdata;
                    mem_we       = {4{a_we}} & a_be;
                    state_d      = DONE_A;
                    last_grant_d = GRANT_A;
                end else if (win_b) begin
                    mem_addr     = b_addr;
                    mem_din      = b_wdata;
                    mem_we       = {4{b_we}} & b_be;
                    state_d      = DONE_B;
                    last_grant_d = GRANT_B;
                end
            end
            // Completion is suppressed while reset is held so an interrupted access never acks.
            DONE_A: begin
                a_ack   = reset_n;
                a_rdata = reset_n ? mem_dout : 32'h0;
                state_d = IDLE;
            end
            DONE_B: begin
                b_ack   = reset_n;
                b_rdata = reset_n ? mem_dout : 32'h0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_2port_32bit.sv
// Table-driven bench for mem_arbiter_2port_32bit with a four-lane byte RAM model behind it.
// Table rows are applied one per clock; multi-cycle reset and tie cases are hand-written sequences.
module tb_mem_arbiter_2port_32bit;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [3:0]    a_be, b_be, mem_we;
    logic [31:0]   a_wdata, b_wdata, a_rdata, b_rdata, mem_din, mem_dout;
    logic          a_ack, b_ack;

    always #5 clk = ~clk;

    mem_arbiter_2port_32bit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    // RAM model: address registered at the edge, read data combinational from that address.
    logic [7:0]    ram [0:3][0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) ram[i][mem_addr] <= mem_din[8*i +: 8];
        ram_addr_q <= mem_addr;
    end

    assign mem_dout = {ram[3][ram_addr_q], ram[2][ram_addr_q], ram[1][ram_addr_q], ram[0][ram_addr_q]};

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
        for (int i = 0; i < 4; i++) ram[i][addr] = data[8*i +: 8];
    endtask

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_be = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_be = '0; b_wdata = '0;
    endtask

    typedef struct {
        logic          a_req, a_we;
        logic [AW-1:0] a_addr;
        logic [3:0]    a_be;
        logic [31:0]   a_wdata;
        logic          b_req, b_we;
        logic [AW-1:0] b_addr;
        logic [3:0]    b_be;
        logic [31:0]   b_wdata;
        logic [1:0]    e_ack;     // {a_ack, b_ack}
        logic [31:0]   e_a_rd, e_b_rd;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_din;
        logic          chk_rd;    // read data of a write completion is don't-care
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic ar, aw, input logic [AW-1:0] aa, input logic [3:0] abe, input logic [31:0] awd,
        input logic br, bw, input logic [AW-1:0] ba, input logic [3:0] bbe, input logic [31:0] bwd,
        input logic [1:0] ack, input logic [31:0] ard, brd,
        input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] din, input logic crd);
        vec_t r;
        r.a_req = ar; r.a_we = aw; r.a_addr = aa; r.a_be = abe; r.a_wdata = awd;
        r.b_req = br; r.b_we = bw; r.b_addr = ba; r.b_be = bbe; r.b_wdata = bwd;
        r.e_ack = ack; r.e_a_rd = ard; r.e_b_rd = brd;
        r.e_we = we; r.e_addr = addr; r.e_din = din; r.chk_rd = crd;
        return r;
    endfunction

    logic [1:0]    tie_ack  [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [AW-1:0] tie_addr [6] = '{14'h10, 14'h0, 14'h20, 14'h0, 14'h10, 14'h0};

    initial begin
        // row: a{req,we,addr,be,wdata} b{req,we,addr,be,wdata} | {a_ack,b_ack} a_rd b_rd mem_we mem_addr mem_din chk_rd
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0010,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'hDEADBEEF,32'h0, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        1,1,14'h20,4'b0101,32'h11223344, 2'b00,32'h0,32'h0,     4'b0101,14'h0020,32'h11223344,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b01,32'h0,32'h0,        4'h0,14'h0000,32'h0,0));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        1,0,14'h20,4'hF,32'h0,         2'b00,32'h0,32'h0,        4'h0,14'h0020,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b01,32'h0,32'hAA22CC44, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(1,1,14'h0030,4'h0,32'hFFFFFFFF, 0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0030,32'hFFFFFFFF,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'h0,32'h0,        4'h0,14'h0000,32'h0,0));
        vecs.push_back(v(1,0,14'h0030,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0030,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'h12345678,32'h0, 4'h0,14'h0000,32'h0,1));
        // tie with last grant = A: B, then A, then B while both held
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h55,       1,0,14'h20,4'hF,32'h66,        2'b00,32'h0,32'h0,        4'h0,14'h0020,32'h66,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h55,       1,0,14'h20,4'hF,32'h66,        2'b01,32'h0,32'hAA22CC44, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h55,       1,0,14'h20,4'hF,32'h66,        2'b00,32'h0,32'h0,        4'h0,14'h0010,32'h55,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h55,       1,0,14'h20,4'hF,32'h66,        2'b10,32'hDEADBEEF,32'h0, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h55,       1,0,14'h20,4'hF,32'h66,        2'b00,32'h0,32'h0,        4'h0,14'h0020,32'h66,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b01,32'h0,32'hAA22CC44, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0000,32'h0,1));
        // top address passes through unmodified
        vecs.push_back(v(1,0,14'h3FFF,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h3FFF,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'hCAFEF00D,32'h0, 4'h0,14'h0000,32'h0,1));
        // single continuous requester: one grant every 2 cycles
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0010,32'h0,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'hDEADBEEF,32'h0, 4'h0,14'h0000,32'h0,1));
        vecs.push_back(v(1,0,14'h0010,4'hF,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b00,32'h0,32'h0,        4'h0,14'h0010,32'h0,1));
        vecs.push_back(v(0,0,14'h0000,4'h0,32'h0,        0,0,14'h0,4'h0,32'h0,          2'b10,32'hDEADBEEF,32'h0, 4'h0,14'h0000,32'h0,1));

        preload(14'h0010, 32'hDEADBEEF);
        preload(14'h0020, 32'hAABBCCDD);
        preload(14'h0030, 32'h12345678);
        preload(14'h3FFF, 32'hCAFEF00D);

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_acks",  {30'h0, a_ack, b_ack}, 32'h0);
        chk("reset_rdata", a_rdata | b_rdata, 32'h0);
        chk("reset_mem",   {14'h0, mem_we, mem_addr} | mem_din, 32'h0);
        step();
        reset_n = 1'b1;

        // tie straight after reset: A wins first, then alternation
        a_req = 1; a_addr = 14'h10; a_be = 4'hF;
        b_req = 1; b_addr = 14'h20; b_be = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("tie_ack_c%0d", c), {30'h0, a_ack, b_ack}, {30'h0, tie_ack[c]});
            chk($sformatf("tie_addr_c%0d", c), {18'h0, mem_addr}, {18'h0, tie_addr[c]});
            step();
        end
        idle_inputs();

        foreach (vecs[i]) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr;
            a_be = vecs[i].a_be; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr;
            b_be = vecs[i].b_be; b_wdata = vecs[i].b_wdata;
            @(negedge clk);
            chk($sformatf("row%0d_ack", i), {30'h0, a_ack, b_ack}, {30'h0, vecs[i].e_ack});
            chk($sformatf("row%0d_mem_we", i), {28'h0, mem_we}, {28'h0, vecs[i].e_we});
            chk($sformatf("row%0d_mem_addr", i), {18'h0, mem_addr}, {18'h0, vecs[i].e_addr});
            chk($sformatf("row%0d_mem_din", i), mem_din, vecs[i].e_din);
            if (vecs[i].chk_rd) begin
                chk($sformatf("row%0d_a_rdata", i), a_rdata, vecs[i].e_a_rd);
                chk($sformatf("row%0d_b_rdata", i), b_rdata, vecs[i].e_b_rd);
            end
            step();
        end
        idle_inputs();

        // reset during DONE_B: no ack in that cycle or the next, then a tie goes to A
        b_req = 1; b_addr = 14'h10; b_be = 4'hF;
        @(negedge clk);
        chk("rstdone_issue_addr", {18'h0, mem_addr}, 32'h10);
        step();
        b_req = 0; reset_n = 1'b0;
        @(negedge clk);
        chk("rstdone_ack_in_done", {30'h0, a_ack, b_ack}, 32'h0);
        chk("rstdone_rdata_in_done", b_rdata, 32'h0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstdone_ack_after", {30'h0, a_ack, b_ack}, 32'h0);
        chk("rstdone_idle_mem", {14'h0, mem_we, mem_addr}, 32'h0);
        step();
        a_req = 1; a_addr = 14'h30; a_be = 4'hF;
        b_req = 1; b_addr = 14'h20; b_be = 4'hF;
        @(negedge clk);
        chk("rstdone_tie_addr", {18'h0, mem_addr}, 32'h30);
        step();
        idle_inputs();
        @(negedge clk);
        chk("rstdone_tie_ack", {30'h0, a_ack, b_ack}, 32'h2);
        chk("rstdone_tie_rdata", a_rdata, 32'h12345678);
        step();

        // reset during an issue cycle: the write still lands but there is no ack
        a_req = 1; a_we = 1; a_addr = 14'h40; a_be = 4'hF; a_wdata = 32'h5A5A5A5A;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstissue_mem_we", {28'h0, mem_we}, 32'hF);
        step();
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rstissue_no_ack", {30'h0, a_ack, b_ack}, 32'h0);
        step();
        a_req = 1; a_addr = 14'h40; a_be = 4'h0;
        step();
        a_req = 0;
        @(negedge clk);
        chk("rstissue_readback", a_rdata, 32'h5A5A5A5A);
        step();
        idle_inputs();

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d", c),
                {a_ack, b_ack, mem_we, mem_addr} | a_rdata | b_rdata | mem_din, 32'h0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
